seg7_scan_decoder: RTL and testbench

- Receive-side counterpart of the team's hex-to-seven-segment encoder.
- Samples a multiplexed, active-low seven-segment display bus (segment lines plus digit anodes) and decodes each stable segment pattern back to its 4-bit hex value.
- Assembles one value per digit and presents the complete multi-digit frame on a valid/ready handshake.
- Used for board-level loopback checking of display drivers and for reading external seven-segment modules.

---
 rtl/seg7_pkg.sv | 66 ++++++
 rtl/seg7_glyph_decode.sv | 17 +
 rtl/seg7_scan_decoder.sv | 166 ++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg7_pkg: shared seven-segment glyph table, scan FSM states and decoder. |
// | Optional build macro: SEG7_BCD_CHECK_EN (flag A-F glyphs as errors).     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package seg7_pkg;

    localparam logic [6:0] SEG7_0 = 7'h40;
    localparam logic [6:0] SEG7_1 = 7'h79;
    localparam logic [6:0] SEG7_2 = 7'h24;
    localparam logic [6:0] SEG7_3 = 7'h30;
    localparam logic [6:0] SEG7_4 = 7'h19;
    localparam logic [6:0] SEG7_5 = 7'h12;
    localparam logic [6:0] SEG7_6 = 7'h02;
    localparam logic [6:0] SEG7_7 = 7'h78;
    localparam logic [6:0] SEG7_8 = 7'h00;
    localparam logic [6:0] SEG7_9 = 7'h18;
    localparam logic [6:0] SEG7_A = 7'h08;
    localparam logic [6:0] SEG7_B = 7'h03;
    localparam logic [6:0] SEG7_C = 7'h46;
    localparam logic [6:0] SEG7_D = 7'h21;
    localparam logic [6:0] SEG7_E = 7'h06;
    localparam logic [6:0] SEG7_F = 7'h0E;

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_LATCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    // Returns {err, nibble}; unknown patterns yield nibble 0 with err set.
    function automatic logic [4:0] seg7_decode(input logic [6:0] seg);
        logic [3:0] nibble;
        logic       err;
        nibble = 4'h0;
        err    = 1'b0;
        case (seg)
            SEG7_0:  nibble = 4'h0;
            SEG7_1:  nibble = 4'h1;
            SEG7_2:  nibble = 4'h2;
            SEG7_3:  nibble = 4'h3;
            SEG7_4:  nibble = 4'h4;
            SEG7_5:  nibble = 4'h5;
            SEG7_6:  nibble = 4'h6;
            SEG7_7:  nibble = 4'h7;
            SEG7_8:  nibble = 4'h8;
            SEG7_9:  nibble = 4'h9;
            SEG7_A:  nibble = 4'hA;
            SEG7_B:  nibble = 4'hB;
            SEG7_C:  nibble = 4'hC;
            SEG7_D:  nibble = 4'hD;
            SEG7_E:  nibble = 4'hE;
            SEG7_F:  nibble = 4'hF;
            default: err    = 1'b1;
        endcase
`ifdef SEG7_BCD_CHECK_EN
        if (!err && nibble > 4'h9) begin
            err = 1'b1;
        end
`endif
        return {err, nibble};
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_glyph_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg7_glyph_decode: combinational active-low glyph to nibble/err decoder. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       err
);

    assign {err, nibble} = seg7_decode(seg);

endmodule
`default_nettype wire

// File: rtl/seg7_scan_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg7_scan_decoder: samples a multiplexed seven-segment bus and presents  |
// | each complete multi-digit frame on a valid/ready handshake.              |
// | Optional build macro: SEG7_BCD_CHECK_EN.                                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 8,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          seg_in,
    input  logic [DIGITS-1:0]   an_in,
    output logic [4*DIGITS-1:0] out_value,
    output logic [DIGITS-1:0]   out_err,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                overrun
);

    localparam int                 C_CNT_W  = $clog2(STABLE_CYCLES + 1);
    localparam logic [C_CNT_W-1:0] C_STABLE = C_CNT_W'(STABLE_CYCLES);
    localparam logic [C_CNT_W-1:0] C_ONE    = C_CNT_W'(1);
    localparam int                 C_BUS_W  = 7 + DIGITS;

    logic [C_BUS_W-1:0]  r_sync [SYNC_STAGES];
    logic [C_BUS_W-1:0]  w_bus;
    logic [C_BUS_W-1:0]  r_last;
    logic [C_BUS_W-1:0]  r_cap;
    logic [C_CNT_W-1:0]  r_count;
    logic [C_CNT_W-1:0]  w_count;
    logic                w_changed;
    logic [DIGITS-1:0]   w_an_low;
    logic                w_one_hot;
    logic [DIGITS-1:0]   w_last_low;
    state_t              r_state;
    state_t              w_state_next;
    logic                w_latch;
    logic [3:0]          w_nibble;
    logic                w_err;
    logic [4*DIGITS-1:0] r_digits;
    logic [DIGITS-1:0]   r_errs;
    logic [DIGITS-1:0]   r_seen;
    logic [DIGITS-1:0]   w_seen_next;
    logic                w_complete;

    // Synchronizer idles at the blank bus value (all lines high).
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '1;
            end
        end else begin
            r_sync[0] <= {seg_in, an_in};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_bus     = r_sync[SYNC_STAGES-1];
    assign w_changed = (w_bus != r_last);
    assign w_an_low  = ~w_bus[DIGITS-1:0];
    assign w_one_hot = (w_an_low != '0) && ((w_an_low & (w_an_low - DIGITS'(1))) == '0);

    // w_count is the run length including the current cycle.
    always_comb begin
        w_count = r_count;
        if (w_changed) begin
            w_count = C_ONE;
        end else if (r_count != C_STABLE) begin
            w_count = r_count + C_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last  <= '1;
            r_count <= '0;
        end else begin
            r_last  <= w_bus;
            r_count <= w_count;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_WAIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // HOLD compares against the captured pattern, so a change landing during
    // LATCH still releases the FSM.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_WAIT:  if (w_count == C_STABLE && w_one_hot) w_state_next = S_LATCH;
            S_LATCH: w_state_next = S_HOLD;
            S_HOLD:  if (w_bus != r_cap) w_state_next = S_WAIT;
            default: w_state_next = S_WAIT;
        endcase
    end

    always_comb begin
        w_latch = (r_state == S_LATCH);
    end

    // r_last holds the pattern that satisfied the stability test.
    assign w_last_low = ~r_last[DIGITS-1:0];

    seg7_glyph_decode u_glyph_decode (
        .seg    (r_last[C_BUS_W-1:DIGITS]),
        .nibble (w_nibble),
        .err    (w_err)
    );

    assign w_complete  = &r_seen;
    assign w_seen_next = (w_complete ? '0 : r_seen) | (w_latch ? w_last_low : '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cap    <= '1;
            r_digits <= '0;
            r_errs   <= '0;
            r_seen   <= '0;
        end else begin
            r_seen <= w_seen_next;
            if (w_latch) begin
                r_cap <= r_last;
                for (int i = 0; i < DIGITS; i++) begin
                    if (w_last_low[i]) begin
                        r_digits[4*i +: 4] <= w_nibble;
                        r_errs[i]          <= w_err;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_value <= '0;
            out_err   <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (w_complete) begin
            out_value <= r_digits;
            out_err   <= r_errs;
            out_valid <= 1'b1;
            if (out_valid && !out_ready) begin
                overrun <= 1'b1;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_seg7_scan_decoder: randomized self-checking bench with a run-length   |
// | reference model of the display scan capture.                             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_seg7_scan_decoder;

    localparam int S = 8;

    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct packed {
        logic [15:0] v;
        logic [3:0]  e;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [6:0]  seg_in = 7'h7F;
    logic [3:0]  an_in = 4'hF;
    logic [15:0] out_value;
    logic [3:0]  out_err;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        overrun;

    int checks = 0;
    int errors = 0;
    int lat    = 0;

    // Reference model: a pin pattern held S cycles on one anode is captured once.
    logic [6:0]  m_seg;
    logic [3:0]  m_an;
    int          m_run;
    logic [15:0] m_val;
    logic [3:0]  m_err;
    logic [3:0]  m_seen;
    frame_t      exp_q[$];
    frame_t      got_q[$];

    always #5 clk = ~clk;

    seg7_scan_decoder #(
        .DIGITS        (4),
        .STABLE_CYCLES (S),
        .SYNC_STAGES   (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_in    (seg_in),
        .an_in     (an_in),
        .out_value (out_value),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun)
    );

    always @(negedge clk) begin
        if (rst && out_valid && out_ready) got_q.push_back({out_value, out_err});
    end

    function automatic void model_reset();
        m_seg  = 7'h7F;
        m_an   = 4'hF;
        m_run  = 0;
        m_val  = '0;
        m_err  = '0;
        m_seen = '0;
    endfunction

    function automatic void model_decode(input logic [6:0] s, output logic [3:0] n, output logic e);
        n = 4'h0;
        e = 1'b1;
        for (int g = 0; g < 16; g++) begin
            if (GLYPH[g] == s) begin
                n = 4'(g);
                e = 1'b0;
`ifdef SEG7_BCD_CHECK_EN
                e = (g > 9);
`endif
            end
        end
    endfunction

    function automatic void model_step(input logic [6:0] s, input logic [3:0] a);
        int         lows;
        int         idx;
        logic [3:0] n;
        logic       e;
        if (s == m_seg && a == m_an) m_run++;
        else begin
            m_seg = s;
            m_an  = a;
            m_run = 1;
        end
        lows = 0;
        idx  = 0;
        for (int i = 0; i < 4; i++) begin
            if (!a[i]) begin
                lows++;
                idx = i;
            end
        end
        if (m_run == S && lows == 1) begin
            model_decode(s, n, e);
            m_val[4*idx +: 4] = n;
            m_err[idx]        = e;
            m_seen[idx]       = 1'b1;
            if (m_seen == 4'hF) begin
                exp_q.push_back({m_val, m_err});
                m_seen = '0;
            end
        end
    endfunction

    task automatic drive(input logic [6:0] s, input logic [3:0] a, input int n);
        seg_in = s;
        an_in  = a;
        for (int k = 0; k < n; k++) begin
            model_step(s, a);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic blank(input int n);
        drive(7'h7F, 4'hF, n);
    endtask

    task automatic drive_digit(input int i, input logic [6:0] s, input int n);
        drive(s, ~(4'b0001 << i), n);
    endtask

    task automatic scan_value(input logic [15:0] v, input int dur);
        for (int i = 0; i < 4; i++) drive_digit(i, GLYPH[v[4*i +: 4]], dur);
    endtask

    task automatic do_reset(input int n);
        seg_in = 7'h7F;
        an_in  = 4'hF;
        rst    = 1'b0;
        model_reset();
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic flush();
        out_ready = 1'b1;
        blank(3);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        seg_in = 7'($urandom);
        an_in  = 4'($urandom);
        rst    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++; if (out_value !== 16'h0) begin errors++; $display("FAIL reset_value got %h want 0000", out_value); end
        checks++; if (out_err !== 4'h0) begin errors++; $display("FAIL reset_err got %b want 0000", out_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
        do_reset(1);
    endtask

    task automatic test_clean_scan();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) drive_digit(i, GLYPH[i+1], 20);
        seg_in = GLYPH[4];
        an_in  = 4'b0111;
        for (int k = 1; k <= 20; k++) begin
            model_step(GLYPH[4], 4'b0111);
            @(posedge clk);
            #1;
            if (lat == 0 && out_valid === 1'b1) lat = k;
        end
        blank(5);
        checks++; if (lat == 0) begin errors++; $display("FAIL clean_timeout got no out_valid within 20 cycles"); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL clean_valid got %b want 1", out_valid); end
        checks++; if (out_value !== 16'h4321) begin errors++; $display("FAIL clean_value got %h want 4321", out_value); end
        checks++; if (out_err !== 4'h0) begin errors++; $display("FAIL clean_err got %b want 0000", out_err); end
        blank(10);
        checks++;
        if (out_valid !== 1'b1 || out_value !== 16'h4321) begin
            errors++; $display("FAIL clean_hold got valid=%b value=%h want 1/4321", out_valid, out_value);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clean_drop got %b want 0", out_valid); end
    endtask

    task automatic test_glitch();
        flush();
        drive_digit(0, GLYPH[7], 20);
        drive_digit(1, GLYPH[9], 20);
        drive_digit(2, GLYPH[8], S - 1);
        drive_digit(2, GLYPH[5], 20);
        drive_digit(3, GLYPH[3], 20);
        blank(20);
        checks++;
        if (out_valid !== 1'b1 || out_value !== 16'h3597) begin
            errors++; $display("FAIL glitch_value got valid=%b value=%h want 1/3597", out_valid, out_value);
        end
        checks++; if (out_err !== 4'h0) begin errors++; $display("FAIL glitch_err got %b want 0000", out_err); end
    endtask

    task automatic test_illegal();
        flush();
        drive_digit(0, GLYPH[0], 20);
        drive_digit(1, 7'h7F, 20);
        drive_digit(2, GLYPH[1], 20);
        drive_digit(3, GLYPH[2], 20);
        blank(20);
        checks++; if (out_err !== 4'b0010) begin errors++; $display("FAIL illegal_err got %b want 0010", out_err); end
        checks++; if (out_value !== 16'h2100) begin errors++; $display("FAIL illegal_value got %h want 2100", out_value); end
`ifdef SEG7_BCD_CHECK_EN
        flush();
        drive_digit(0, GLYPH[10], 20);
        drive_digit(1, GLYPH[1], 20);
        drive_digit(2, GLYPH[2], 20);
        drive_digit(3, GLYPH[3], 20);
        blank(20);
        checks++; if (out_err !== 4'b0001) begin errors++; $display("FAIL bcd_err got %b want 0001", out_err); end
        checks++; if (out_value !== 16'h321A) begin errors++; $display("FAIL bcd_value got %h want 321A", out_value); end
`endif
    endtask

    task automatic test_overrun();
        flush();
        scan_value(16'h1357, 20);
        blank(20);
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_early got %b want 0", overrun); end
        scan_value(16'h2468, 20);
        blank(20);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag got %b want 1", overrun); end
        checks++; if (out_value !== 16'h2468) begin errors++; $display("FAIL overrun_value got %h want 2468", out_value); end
        for (int i = 0; i < 3; i++) drive_digit(i, GLYPH[(i == 0) ? 2 : ((i == 1) ? 1 : 0)], 20);
        seg_in = GLYPH[9];
        an_in  = 4'b0111;
        for (int k = 1; k <= 30; k++) begin
            model_step(GLYPH[9], 4'b0111);
            @(posedge clk);
            #1;
            if (k == lat - 1) out_ready = 1'b1;
            if (k == lat) begin
                out_ready = 1'b0;
                checks++;
                if (out_valid !== 1'b1 || out_value !== 16'h9012) begin
                    errors++; $display("FAIL same_cycle_load got valid=%b value=%h want 1/9012", out_valid, out_value);
                end
            end
            if (k == lat + 1) begin
                checks++;
                if (out_valid !== 1'b1) begin errors++; $display("FAIL same_cycle_hold got %b want 1", out_valid); end
            end
        end
        blank(5);
    endtask

    task automatic test_mid_reset();
        flush();
        drive_digit(0, GLYPH[8], 20);
        drive_digit(1, GLYPH[6], 20);
        do_reset(1);
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL midreset_overrun got %b want 0", overrun); end
        drive_digit(2, GLYPH[6], 20);
        drive_digit(3, GLYPH[7], 20);
        blank(20);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_partial got valid=%b want 0", out_valid); end
        drive_digit(0, GLYPH[4], 20);
        drive_digit(1, GLYPH[5], 20);
        blank(20);
        checks++;
        if (out_valid !== 1'b1 || out_value !== 16'h7654 || out_err !== 4'h0) begin
            errors++; $display("FAIL midreset_frame got valid=%b value=%h err=%b want 1/7654/0000", out_valid, out_value, out_err);
        end
    endtask

    task automatic test_random();
        logic [6:0] g;
        int         d;
        flush();
        exp_q.delete();
        got_q.delete();
        out_ready = 1'b1;
        for (int step = 0; step < 400 && exp_q.size() < 6; step++) begin
            d = int'($urandom_range(3, 0));
            if ($urandom_range(7, 0) == 0) g = 7'($urandom);
            else g = GLYPH[$urandom_range(15, 0)];
            if ($urandom_range(3, 0) == 0) drive_digit(d, 7'($urandom), int'($urandom_range(S - 1, 1)));
            if ($urandom_range(7, 0) == 0) drive(g, 4'b0101, S + 2);
            drive_digit(d, g, int'($urandom_range(S + 8, S)));
            blank(int'($urandom_range(3, 0)));
        end
        blank(30);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL random_count got %0d frames want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL random_frame%0d got %h/%b want %h/%b", i, got_q[i].v, got_q[i].e, exp_q[i].v, exp_q[i].e);
            end
        end
        out_ready = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_clean_scan();
        test_glitch();
        test_illegal();
        test_overrun();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
